// File: rtl/cpu_run_monitor.sv
// Run-control and observation block beside the cpu core: counts run statistics,
// detects end-of-program or timeout, drains, halts the core and dumps the register file.
module cpu_run_monitor #(
  parameter int          XLEN         = 32,
  parameter int          PC_BITS      = 20,
  parameter int          REG_NUM      = 32,
  parameter int          ADDR_SIZE    = 5,
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 5,
  parameter int          TIMEOUT      = 2000,
  parameter logic [31:0] END_INST     = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 F_valid,
  input  logic [31:0]          F_inst,
  input  logic [PC_BITS-1:0]   F_pc,
  input  logic                 stall_D,
  input  logic                 EX_true_taken,
  output logic                 halt,
  output logic [ADDR_SIZE-1:0] dbg_rd_addr,
  input  logic [XLEN-1:0]      dbg_rd_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_SIZE-1:0] dump_idx,
  output logic [XLEN-1:0]      dump_data,
  output logic                 done,
  output logic                 timed_out,
  output logic [PC_BITS-1:0]   end_pc,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     taken_cnt
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP, DONE} state_t;

  localparam logic [CNT_W-1:0]     TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [7:0]           DRAIN_C    = 8'(DRAIN_CYCLES);
  localparam logic [ADDR_SIZE-1:0] LAST_IDX   = ADDR_SIZE'(REG_NUM - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       taken_cnt_q, taken_cnt_d;
  logic [PC_BITS-1:0]     end_pc_q, end_pc_d;
  logic                   timed_out_q, timed_out_d;
  logic [7:0]             drain_q, drain_d;
  logic [ADDR_SIZE-1:0]   dump_idx_q, dump_idx_d;
  logic                   end_hit;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  assign end_hit = F_valid && (F_inst == END_INST);

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    end_pc_d    = end_pc_q;
    timed_out_d = timed_out_q;
    drain_d     = drain_q;
    dump_idx_d  = dump_idx_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cycle_cnt_d = '0;
          stall_cnt_d = '0;
          taken_cnt_d = '0;
          end_pc_d    = '0;
          timed_out_d = 1'b0;
          dump_idx_d  = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // End detection takes priority over a coincident timeout.
        if (end_hit) begin
          cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
          stall_cnt_d = sat_inc(stall_cnt_q, stall_D);
          taken_cnt_d = sat_inc(taken_cnt_q, EX_true_taken);
          end_pc_d    = F_pc;
          drain_d     = DRAIN_C;
          state_d     = DRAIN;
        end else if (cycle_cnt_q == TIMEOUT_C) begin
          timed_out_d = 1'b1;
          end_pc_d    = F_pc;
          dump_idx_d  = '0;
          state_d     = DUMP;
        end else begin
          cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
          stall_cnt_d = sat_inc(stall_cnt_q, stall_D);
          taken_cnt_d = sat_inc(taken_cnt_q, EX_true_taken);
        end
      end
      DRAIN: begin
        if (drain_q <= 8'd1) begin
          drain_d    = '0;
          dump_idx_d = '0;
          state_d    = DUMP;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            dump_idx_d = '0;
            state_d    = DONE;
          end else begin
            dump_idx_d = dump_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
      end_pc_q    <= '0;
      timed_out_q <= 1'b0;
      drain_q     <= '0;
      dump_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      end_pc_q    <= end_pc_d;
      timed_out_q <= timed_out_d;
      drain_q     <= drain_d;
      dump_idx_q  <= dump_idx_d;
    end
  end

  assign halt        = (state_q == DUMP) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign dump_valid  = (state_q == DUMP);
  assign dbg_rd_addr = dump_idx_q;
  assign dump_idx    = dump_idx_q;
  assign dump_data   = dump_valid ? dbg_rd_data : '0;
  assign timed_out   = timed_out_q;
  assign end_pc      = end_pc_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: end detection, drain, dump flow control,
// timeout, end/timeout tie and asynchronous reset during a dump.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        F_valid;
  logic [31:0] F_inst;
  logic [19:0] F_pc;
  logic        stall_D;
  logic        EX_true_taken;
  logic        halt;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        done;
  logic        timed_out;
  logic [19:0] end_pc;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Register file model: regs[i] = i*3
  assign dbg_rd_data = {27'b0, dbg_rd_addr} * 32'd3;

  cpu_run_monitor dut (
    .clk(clk), .rst(rst), .start(start),
    .F_valid(F_valid), .F_inst(F_inst), .F_pc(F_pc),
    .stall_D(stall_D), .EX_true_taken(EX_true_taken),
    .halt(halt), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .done(done), .timed_out(timed_out), .end_pc(end_pc),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of run inputs, then sample just after the edge
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [19:0] pc,
                               input logic st, input logic tk);
    F_valid       = v;
    F_inst        = inst;
    F_pc          = pc;
    stall_D       = st;
    EX_true_taken = tk;
    @(posedge clk); #1;
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_halt"}, 64'(halt), 0);
    checkOutput({tag, "_valid"}, 64'(dump_valid), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_tout"}, 64'(timed_out), 0);
    checkOutput({tag, "_endpc"}, 64'(end_pc), 0);
    checkOutput({tag, "_cyc"}, 64'(cycle_cnt), 0);
    checkOutput({tag, "_stall"}, 64'(stall_cnt), 0);
    checkOutput({tag, "_taken"}, 64'(taken_cnt), 0);
    checkOutput({tag, "_rdaddr"}, 64'(dbg_rd_addr), 0);
    checkOutput({tag, "_idx"}, 64'(dump_idx), 0);
    checkOutput({tag, "_data"}, 64'(dump_data), 0);
  endtask

  // Drain is exactly 5 clocks: halt low after 4, high after the 5th
  task automatic drainFive(input string tag);
    for (int d = 1; d <= 5; d++) begin
      applyStimulus(1'b1, 32'h0, 20'h55, 1'b1, 1'b1);
      if (d == 4) checkOutput({tag, "_halt_d4"}, 64'(halt), 0);
    end
    checkOutput({tag, "_halt_d5"}, 64'(halt), 1);
    checkOutput({tag, "_valid_d5"}, 64'(dump_valid), 1);
    applyStimulus(1'b0, 32'h13, 20'h0, 1'b0, 1'b0);
  endtask

  // Collect a full dump with a repeating dump_ready pattern; pattern bit n is used on cycle n%4
  task automatic dumpCollect(input string tag, input logic [3:0] pat);
    int          beats = 0;
    logic        held  = 1'b0;
    logic [4:0]  p_idx = '0;
    logic [31:0] p_data = '0;
    for (int cyc = 0; cyc < 200 && beats < 32; cyc++) begin
      dump_ready = pat[cyc % 4];
      if (held) begin
        checkOutput({tag, "_hold_valid"}, 64'(dump_valid), 1);
        checkOutput({tag, "_hold_idx"}, 64'(dump_idx), 64'(p_idx));
        checkOutput({tag, "_hold_data"}, 64'(dump_data), 64'(p_data));
      end
      if (dump_valid && dump_ready) begin
        checkOutput({tag, "_idx"}, 64'(dump_idx), 64'(beats));
        checkOutput({tag, "_data"}, 64'(dump_data), 64'(beats * 3));
        beats++;
        held = 1'b0;
      end else begin
        held   = dump_valid;
        p_idx  = dump_idx;
        p_data = dump_data;
      end
      @(posedge clk); #1;
    end
    dump_ready = 1'b0;
    checkOutput({tag, "_beats"}, 64'(beats), 32);
    checkOutput({tag, "_done"}, 64'(done), 1);
    checkOutput({tag, "_valid_end"}, 64'(dump_valid), 0);
    checkOutput({tag, "_halt_end"}, 64'(halt), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dump_ready = 1'b0;
    F_valid = 1'b0; F_inst = 32'h13; F_pc = '0; stall_D = 1'b0; EX_true_taken = 1'b0;
    #1;
    checkReset("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Run A: END_INST on run cycle 40 at pc 22, stall 7 cycles, taken 3 cycles
    $display("[TB] run A: end detection and full-rate dump");
    applyStimulus(1'b0, 32'h13, 20'h0, 1'b0, 1'b0);
    startRun();
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, (k == 40) ? 32'h0 : 32'h13 + 32'(k),
                    (k == 40) ? 20'd22 : 20'(100 + k),
                    (k >= 5 && k <= 11), (k == 10 || k == 20 || k == 30));
      if (k == 20) checkOutput("A_cyc_mid", 64'(cycle_cnt), 20);
    end
    checkOutput("A_cyc", 64'(cycle_cnt), 40);
    checkOutput("A_endpc", 64'(end_pc), 22);
    checkOutput("A_stall", 64'(stall_cnt), 7);
    checkOutput("A_taken", 64'(taken_cnt), 3);
    checkOutput("A_tout", 64'(timed_out), 0);
    checkOutput("A_halt_end", 64'(halt), 0);
    drainFive("A");
    checkOutput("A_cyc_frozen", 64'(cycle_cnt), 40);
    checkOutput("A_stall_frozen", 64'(stall_cnt), 7);
    checkOutput("A_taken_frozen", 64'(taken_cnt), 3);
    checkOutput("A_endpc_frozen", 64'(end_pc), 22);
    dumpCollect("dumpA", 4'b1111);

    // Run B: restart from DONE, ready pattern 1,0,0,1
    $display("[TB] run B: restart from done, throttled dump");
    startRun();
    checkOutput("B_done_clr", 64'(done), 0);
    checkOutput("B_halt_clr", 64'(halt), 0);
    checkOutput("B_cyc_clr", 64'(cycle_cnt), 0);
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b1, (k == 5) ? 32'h0 : 32'h13, 20'(200 + k), 1'b0, 1'b0);
    checkOutput("B_cyc", 64'(cycle_cnt), 5);
    checkOutput("B_stall", 64'(stall_cnt), 0);
    checkOutput("B_taken", 64'(taken_cnt), 0);
    checkOutput("B_endpc", 64'(end_pc), 205);
    drainFive("B");
    dumpCollect("dumpB", 4'b1001);

    // Run C: no END_INST -> timeout, straight to DUMP
    $display("[TB] run C: timeout");
    resetDut();
    startRun();
    for (int k = 1; k <= 2000; k++) applyStimulus(1'b1, 32'h13, 20'(k), 1'b0, 1'b0);
    checkOutput("C_cyc_pre", 64'(cycle_cnt), 2000);
    checkOutput("C_halt_pre", 64'(halt), 0);
    applyStimulus(1'b1, 32'h13, 20'h777, 1'b0, 1'b0);
    checkOutput("C_tout", 64'(timed_out), 1);
    checkOutput("C_cyc", 64'(cycle_cnt), 2000);
    checkOutput("C_halt", 64'(halt), 1);
    checkOutput("C_valid", 64'(dump_valid), 1);
    checkOutput("C_idx", 64'(dump_idx), 0);
    checkOutput("C_endpc", 64'(end_pc), 20'h777);

    // Run D: END_INST in the timeout cycle, then reset mid-dump
    $display("[TB] run D: end/timeout tie and reset during dump");
    resetDut();
    startRun();
    for (int k = 1; k <= 2000; k++) applyStimulus(1'b1, 32'h13, 20'(k), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0, 20'd7, 1'b0, 1'b0);
    checkOutput("D_tout", 64'(timed_out), 0);
    checkOutput("D_cyc", 64'(cycle_cnt), 2001);
    checkOutput("D_endpc", 64'(end_pc), 7);
    checkOutput("D_halt", 64'(halt), 0);
    drainFive("D");
    dump_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    dump_ready = 1'b0;
    checkOutput("D_idx10", 64'(dump_idx), 10);
    checkOutput("D_data10", 64'(dump_data), 30);
    rst = 1'b1;
    #1;
    checkReset("rstD");
    @(posedge clk); #1;
    rst = 1'b0;
    startRun();
    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b1, (k == 3) ? 32'h0 : 32'h13, 20'(300 + k), 1'b0, 1'b0);
    checkOutput("E_cyc", 64'(cycle_cnt), 3);
    drainFive("E");
    dumpCollect("dumpE", 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run-control and observation block that sits beside the cpu core and shares its clk and rst. It starts a program run and counts cycles, decode stalls and taken branches. It detects end-of-program on the fetch stream, or a timeout, then drains the pipeline for a programmable number of cycles. It then halts the core and streams the register file out through a valid/ready dump port.

Parameters:
XLEN, 32, register data width
PC_BITS, 20, fetch PC width
REG_NUM, 32, number of architectural registers to dump
ADDR_SIZE, 5, register index width
CNT_W, 32, width of every statistic counter
DRAIN_CYCLES, 5, clocks between end detection and halt (1..255)
TIMEOUT, 2000, cycle limit for a run
END_INST, 32'h00000000, instruction word that marks end-of-program

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts a run from IDLE or DONE
F_valid  in  1  fetch stage holds a valid instruction
F_inst  in  32  fetched instruction word
F_pc  in  PC_BITS  fetch PC
stall_D  in  1  decode stall this cycle
EX_true_taken  in  1  resolved taken branch in EX
halt  out  1  freeze request to core
dbg_rd_addr  out  ADDR_SIZE  register file debug read index
dbg_rd_data  in  XLEN  register file debug read data (combinational read)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump consumer ready
dump_idx  out  ADDR_SIZE  register index of current beat
dump_data  out  XLEN  register value of current beat
done  out  1  run finished and dump complete
timed_out  out  1  run ended by TIMEOUT, not END_INST
end_pc  out  PC_BITS  F_pc captured at end detection
cycle_cnt  out  CNT_W  run cycles up to end detection
stall_cnt  out  CNT_W  cycles with stall_D=1 during RUN
taken_cnt  out  CNT_W  cycles with EX_true_taken=1 during RUN

Behaviour:
- Reset is asynchronous and active-high. It forces IDLE, and every output is 0 (halt=0, dump_valid=0, done=0, timed_out=0, end_pc=0, all counters=0, dbg_rd_addr=0). This applies mid-run and mid-dump too; in-flight dump beats are abandoned.
- States: IDLE, RUN, DRAIN, DUMP, DONE.
- IDLE: on start=1, clear all counters, timed_out and end_pc; RUN is entered next cycle.
- RUN: each clock, cycle_cnt+1. stall_cnt increments if stall_D=1; taken_cnt increments if EX_true_taken=1. All counters saturate at 2^CNT_W-1 and never wrap.
- RUN, end detection: F_valid=1 and F_inst==END_INST. Capture end_pc=F_pc. cycle_cnt includes that cycle and then freezes. Load drain counter = DRAIN_CYCLES and go to DRAIN.
- RUN, timeout: the clock in which cycle_cnt would become TIMEOUT+1. Set timed_out=1, freeze counters, end_pc=F_pc, go directly to DUMP (no drain).
- If end detection and timeout occur in the same cycle, end detection wins and timed_out stays 0.
- DRAIN: counters frozen. The drain counter decrements each clock; at 1 -> DUMP. Total clocks spent in DRAIN = DRAIN_CYCLES.
- DUMP: halt=1. dbg_rd_addr=dump_idx. dump_data=dbg_rd_data, passed through combinationally. dump_valid=1, and dump_idx starts at 0.
  - A beat transfers when dump_valid and dump_ready are both 1; dump_idx then increments.
  - dump_idx, dump_data and dump_valid hold stable while dump_ready=0.
  - The transfer of index REG_NUM-1 moves to DONE next cycle with dump_valid=0.
- DONE: halt=1, done=1. Counters, end_pc and timed_out hold.
  - start=1 clears done and counters, deasserts halt and enters RUN next cycle.
- start is ignored in RUN, DRAIN and DUMP. F_* and EX_* inputs are ignored outside RUN.

Test Plan:
- rst, start at cycle 3, END_INST fetched at F_pc=22 on run cycle 40 -> cycle_cnt=40, end_pc=22, DRAIN exactly 5 clocks, halt rises, dump_valid=1 with dump_idx=0.
- Dump with dump_ready=1 throughout, regs[i]=i*3 -> 32 consecutive beats, dump_data=0,3,...,93, done=1 one cycle after beat 31.
- dump_ready toggled 1,0,0,1 during dump -> dump_idx/dump_data stable while 0, no beat lost or duplicated, still 32 beats total.
- No END_INST ever fetched -> timed_out=1, cycle_cnt=2000, DUMP entered without drain.
- END_INST and timeout in same cycle -> timed_out=0, DRAIN entered. stall_D high 7 cycles and EX_true_taken high 3 cycles in RUN -> stall_cnt=7, taken_cnt=3.
- rst pulse during DUMP at dump_idx=10 -> all outputs 0 immediately (async); a new start gives a full 32-beat dump from idx 0.
